fifo_wptr_ctrl: RTL

Write-side pointer controller for the dual-clock FIFO. It sequences a Gray-coded write pointer, grants write requests, and synchronises the read-domain Gray pointer into clk. It produces full, fill level and overflow status. It sits in the write clock domain between the producer and the FIFO RAM write port, and exports wptr_gray to the read-side controller.

---
 rtl/fifo_ptr_pkg.sv | 25 ++
 rtl/fifo_wptr_ctrl_gray_sync.sv | 29 ++
 rtl/fifo_wptr_ctrl.sv | 86 ++++++++
 3 files changed

// File: rtl/fifo_ptr_pkg.sv
// Shared pointer helpers for the dual-clock FIFO pointer controllers.
// Gray/binary conversions operate on a 32-bit container; callers cast to pointer width.
package fifo_ptr_pkg;

    localparam int unsigned GRAY_MAX_W = 32;

    function automatic int unsigned ptr_width(input int unsigned addr_width);
        return addr_width + 1;
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB down; zero upper bits leave narrower values intact.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b = g;
        for (int unsigned s = 1; s < GRAY_MAX_W; s = s << 1) begin
            b = b ^ (b >> s);
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_wptr_ctrl_gray_sync.sv
// Multi-flop vector synchroniser for a Gray-coded pointer crossing into clk.
module gray_sync #(
    parameter int unsigned WIDTH  = 5,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= din;
            for (int unsigned i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[STAGES-1];

endmodule

// File: rtl/fifo_wptr_ctrl.sv
// Write-side pointer controller for the dual-clock FIFO: Gray write pointer, full/level/overflow.
// Optional registered almost_full threshold enabled by macro WPTR_ALMOST_FULL_EN.
module fifo_wptr_ctrl
    import fifo_ptr_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned AF_THRESH   = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH:0]   rptr_gray_async,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   wptr_gray,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   wr_level,
    output logic                  wr_overflow,
    output logic                  almost_full
);

    localparam int unsigned PTR_W = ptr_width(ADDR_WIDTH);
    // Inverting the two MSBs of the read Gray pointer gives the write Gray value DEPTH ahead.
    localparam logic [PTR_W-1:0] FULL_MASK = PTR_W'(3) << (PTR_W - 2);

    logic [PTR_W-1:0] wbin;
    logic [PTR_W-1:0] wbin_next;
    logic [PTR_W-1:0] wgray_next;
    logic [PTR_W-1:0] rptr_sync;
    logic [PTR_W-1:0] rptr_bin;
    logic             full_next;

    gray_sync #(
        .WIDTH  (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_rptr_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (rptr_gray_async),
        .dout  (rptr_sync)
    );

    always_comb begin
        wr_en      = wr_req & ~full;
        wbin_next  = wbin + PTR_W'(wr_en);
        wgray_next = PTR_W'(bin2gray(GRAY_MAX_W'(wbin_next)));
        rptr_bin   = PTR_W'(gray2bin(GRAY_MAX_W'(rptr_sync)));
        full_next  = (wgray_next == (rptr_sync ^ FULL_MASK));
        waddr      = wbin[ADDR_WIDTH-1:0];
        wr_level   = wbin - rptr_bin;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbin        <= '0;
            wptr_gray   <= '0;
            full        <= 1'b0;
            wr_overflow <= 1'b0;
        end else begin
            wbin        <= wbin_next;
            wptr_gray   <= wgray_next;
            full        <= full_next;
            wr_overflow <= wr_req & full;
        end
    end

`ifdef WPTR_ALMOST_FULL_EN
    localparam logic [PTR_W-1:0] AF_LVL = PTR_W'(AF_THRESH);

    logic [PTR_W-1:0] level_next;

    assign level_next = wbin_next - rptr_bin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            almost_full <= 1'b0;
        end else begin
            almost_full <= (level_next >= AF_LVL);
        end
    end
`else
    assign almost_full = 1'b0;
`endif

endmodule
